// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_arbiter
//  Description : Shares one memory port between an I-cache miss, a D-cache
//                miss and a D-side write-through store. A miss fills a whole
//                block with WORDS reads issued on consecutive cycles. Issues
//                overlap returns, which arrive LATENCY cycles after issue.
//                A store is a single write cycle. Each operation ends with a
//                one-cycle done pulse to its owner.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst              clock; asynchronous active-low reset
//    i_miss, i_miss_addr   I-cache miss request (level, held until i_done)
//    d_miss, d_miss_addr   D-cache miss request (level, held until d_done)
//    d_wr_req/addr/data    D-side store request (level, held until d_done)
//    mem_en/wr/addr/wdata  memory command
//    mem_rdata, mem_rvalid memory read return
//    fill_we/sel/idx/data  cache fill write (sel: 0 = I, 1 = D)
//    i_done, d_done, busy  completion pulses and busy flag
// ============================================================================
module cache_fill_arbiter #(
  parameter int LATENCY = 4,
  parameter int WORDS   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_miss,
  input  logic [15:0]                i_miss_addr,
  input  logic                       d_miss,
  input  logic [15:0]                d_miss_addr,
  input  logic                       d_wr_req,
  input  logic [15:0]                d_wr_addr,
  input  logic [15:0]                d_wr_data,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [15:0]                mem_addr,
  output logic [15:0]                mem_wdata,
  input  logic [15:0]                mem_rdata,
  input  logic                       mem_rvalid,
  output logic                       fill_we,
  output logic                       fill_sel,
  output logic [$clog2(WORDS)-1:0]   fill_idx,
  output logic [15:0]                fill_data,
  output logic                       i_done,
  output logic                       d_done,
  output logic                       busy
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int BO_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] c_WORDS_CNT = CNT_W'(WORDS);
  localparam logic [BO_W-1:0]  c_BO_LAST   = BO_W'(LATENCY - 1);

  localparam logic [2:0] c_BLACKOUT = 3'd0;
  localparam logic [2:0] c_IDLE     = 3'd1;
  localparam logic [2:0] c_FILL     = 3'd2;
  localparam logic [2:0] c_WRITE    = 3'd3;
  localparam logic [2:0] c_DONE     = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [BO_W-1:0]  r_bo_cnt;
  logic [11:0]      r_blk;
  logic             r_owner;      // 1 = D side
  logic             r_last_d;     // last completed op was D side
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_recv_cnt;

  // Word-offset bits of miss addresses are irrelevant: a fill covers the block.
  logic w_unused;
  assign w_unused = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

  // Arbitration: I wins whenever the D side just had its turn; otherwise
  // store beats D miss beats I miss.
  logic w_pick_i;
  logic w_pick_w;
  logic w_any_req;
  assign w_any_req = i_miss | d_miss | d_wr_req;
  assign w_pick_i  = i_miss & (r_last_d | ~(d_wr_req | d_miss));
  assign w_pick_w  = ~w_pick_i & d_wr_req;

  logic w_issue_pend;
  logic w_rx;
  logic w_last_rx;
  assign w_issue_pend = (r_issue_cnt < c_WORDS_CNT);
  // Returns beyond the block size are stray and must not write the cache.
  assign w_rx         = mem_rvalid & (r_recv_cnt < c_WORDS_CNT);
  assign w_last_rx    = w_rx & (r_recv_cnt == c_WORDS_CNT - 1'b1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_BLACKOUT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Reads issued before reset may still return; wait them out.
      c_BLACKOUT: if (r_bo_cnt == c_BO_LAST) w_state_nxt = c_IDLE;
      c_IDLE:     if (w_any_req) w_state_nxt = w_pick_w ? c_WRITE : c_FILL;
      c_FILL:     if (w_last_rx) w_state_nxt = c_DONE;
      c_WRITE:    w_state_nxt = c_DONE;
      c_DONE:     w_state_nxt = c_IDLE;
      default:    w_state_nxt = c_BLACKOUT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: grant capture, counters, fairness bit
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bo_cnt    <= '0;
      r_blk       <= '0;
      r_owner     <= 1'b0;
      r_last_d    <= 1'b0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      case (r_state)
        c_BLACKOUT: begin
          if (r_bo_cnt == c_BO_LAST) r_bo_cnt <= '0;
          else                       r_bo_cnt <= r_bo_cnt + 1'b1;
        end
        c_IDLE: begin
          if (w_any_req) begin
            r_owner     <= ~w_pick_i;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            if (w_pick_i)      r_blk <= i_miss_addr[15:4];
            else if (w_pick_w) r_blk <= d_wr_addr[15:4];
            else               r_blk <= d_miss_addr[15:4];
          end
        end
        c_FILL: begin
          if (w_issue_pend) r_issue_cnt <= r_issue_cnt + 1'b1;
          if (w_rx)         r_recv_cnt  <= r_recv_cnt + 1'b1;
        end
        c_DONE: r_last_d <= r_owner;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic; reset blanks every output immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_we   = 1'b0;
    fill_sel  = 1'b0;
    fill_idx  = '0;
    fill_data = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    busy      = 1'b0;
    if (rst) begin
      busy = (r_state != c_IDLE);
      case (r_state)
        c_FILL: begin
          if (w_issue_pend) begin
            mem_en   = 1'b1;
            mem_addr = {r_blk, r_issue_cnt[IDX_W-1:0], 1'b0};
          end
          if (w_rx) begin
            fill_we   = 1'b1;
            fill_sel  = r_owner;
            fill_idx  = r_recv_cnt[IDX_W-1:0];
            fill_data = mem_rdata;
          end
        end
        c_WRITE: begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = d_wr_addr;
          mem_wdata = d_wr_data;
        end
        c_DONE: begin
          i_done = ~r_owner;
          d_done = r_owner;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_fill_arbiter.md
CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, read-issue to mem_rvalid delay in cycles.
REQ-002 SHALL have parameter WORDS, default 8, words per cache block (fill_idx width = log2(WORDS) = 3).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_miss in 1 and i_miss_addr in 16: I-cache miss request and miss address.
REQ-006 SHALL have ports d_miss in 1 and d_miss_addr in 16: D-cache miss request and miss address.
REQ-007 SHALL have ports d_wr_req in 1, d_wr_addr in 16 and d_wr_data in 16: D-side write-through store.
REQ-008 SHALL have ports mem_en out 1, mem_wr out 1, mem_addr out 16 and mem_wdata out 16: memory command.
REQ-009 SHALL have ports mem_rdata in 16 and mem_rvalid in 1: read return, LATENCY cycles after issue.
REQ-010 SHALL have ports fill_we out 1, fill_sel out 1 (0=I, 1=D), fill_idx out 3 and fill_data out 16: cache fill write.
REQ-011 SHALL have ports i_done out 1, d_done out 1 (one-cycle completion pulses) and busy out 1.

Function
REQ-012 SHALL implement states BLACKOUT, IDLE, FILL, WRITE and DONE.
REQ-013 Requests SHALL be level-sensitive, held by the requester until its done pulse, and sampled only in IDLE.
REQ-014 IDLE arbitration SHALL be d_wr_req > d_miss > i_miss, except that i_miss wins once when the previous completed op was D-side and i_miss is pending (anti-starvation bit last_d).
REQ-015 Grant SHALL register the block address addr[15:4] and the owner, then move to WRITE (store) or FILL (miss) on the next edge; busy = 1 in every state except IDLE.
REQ-016 FILL SHALL issue WORDS reads on consecutive cycles: issue k (k = 0..7) drives mem_en=1, mem_wr=0, mem_addr={blk,k[2:0],1'b0}.
REQ-017 Each mem_rvalid in FILL SHALL produce in the same cycle fill_we=1, fill_idx=recv_cnt, fill_data=mem_rdata, fill_sel=owner; recv_cnt then increments.
REQ-018 Issue and return SHALL overlap (issue k and return k-LATENCY may coincide); issue_cnt stops at WORDS and mem_en=0 thereafter.
REQ-019 The WORDS-th return SHALL move FILL to DONE; DONE SHALL pulse the owner's done for exactly one cycle, update last_d, and return to IDLE.
REQ-020 WRITE SHALL last exactly one cycle with mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, then go to DONE (d_done pulse).
REQ-021 Fill latency SHALL be 1 + WORDS + LATENCY cycles from grant edge to done pulse (13 at defaults); store latency SHALL be 2 cycles.
REQ-022 mem_rvalid outside FILL, or in FILL once recv_cnt = WORDS, SHALL be ignored (no fill_we).
REQ-023 A requester dropping its request mid-operation SHALL NOT abort it; the operation completes and the done pulse still issues.
REQ-024 New requests arriving in FILL, WRITE or DONE SHALL wait; arbitration resumes the cycle after DONE.
REQ-025 When not driven, mem_addr, mem_wdata and fill_data SHALL be 0.

Reset
REQ-026 rst=0 SHALL immediately force all outputs to 0, counters to 0, last_d=0 and state to BLACKOUT, regardless of the state at assertion.
REQ-027 After rst deasserts, BLACKOUT SHALL hold for LATENCY cycles (busy=1, requests ignored, mem_rvalid discarded) so that returns from reads in flight before reset are dropped; it then enters IDLE.

Verification
REQ-028 Fill: after blackout, d_miss=1, d_miss_addr=0x1236 -> reads to 0x1230..0x123E on 8 consecutive cycles; 8 fill_we with fill_sel=1, idx 0..7; d_done 13 cycles after grant.
REQ-029 Priority: d_wr_req, d_miss and i_miss all asserted in the same cycle -> WRITE first (d_done after 2 cycles), then I fill (anti-starvation), then D fill.
REQ-030 Starvation: d_miss held continuously with i_miss pending -> grants alternate D, I, D, with no two consecutive D grants while i_miss is pending.
REQ-031 Reset mid-fill: rst=0 after 3 issues, with the bench returning mem_rvalid for them after rst=1 -> no fill_we during blackout, busy=1 for 4 cycles, then clean IDLE.
REQ-032 Spurious rvalid: mem_rvalid pulsed in IDLE and after the 8th return -> no fill_we, state unchanged.
REQ-033 Request drop: i_miss deasserted in the 2nd FILL cycle -> all 8 fills still occur and i_done pulses once.
